// File: rtl/vga_fb_if.sv
// rtl/vga_fb_if.sv - host write port of the VGA framebuffer
//
// Signals:
//   wr_valid  host -> fb  write request
//   wr_ready  fb -> host  write accepted when wr_valid & wr_ready
//   wr_x      host -> fb  framebuffer column (0..FB_W-1 are stored)
//   wr_y      host -> fb  framebuffer row    (0..FB_H-1 are stored)
//   wr_data   host -> fb  colour {r[1:0], g[1:0], b[1:0]}
// Modports: master (host side), slave (framebuffer side).

interface vga_fb_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_x;
   logic [6:0] wr_y;
   logic [5:0] wr_data;

   modport master (output wr_valid, output wr_x, output wr_y, output wr_data,
                   input  wr_ready);
   modport slave  (input  wr_valid, input  wr_x, input  wr_y, input  wr_data,
                   output wr_ready);
endinterface

// File: rtl/vga_fb.sv
// rtl/vga_fb.sv - scaled 6-bit colour framebuffer for a 640x480 VGA display
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pix_en              pixel strobe (one clk in four), x/y/syncs valid on it
//   x, y                current display column/row from the timing generator
//   hsync_in, vsync_in  syncs from the timing generator
//   wr                  host write port (vga_fb_if.slave)
//   clear               single-cycle request to zero the framebuffer
//   busy                high while the clear sweep runs
//   hsync, vsync        syncs delayed one pixel period to match colour
//   r, g, b             pixel colour to the DAC
// Optional feature: define VGA_FB_BORDER_EN to force the outermost display
// rows/columns to white.

module vga_fb #(
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int SCALE_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        hsync_in,
   input  logic        vsync_in,
   vga_fb_if.slave     wr,
   input  logic        clear,
   output logic        busy,
   output logic        hsync,
   output logic        vsync,
   output logic [1:0]  r,
   output logic [1:0]  g,
   output logic [1:0]  b
);

   localparam int DEPTH  = FB_W * FB_H;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt;

   logic [5:0]        mem [0:DEPTH-1];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [5:0]        mem_wdata;

   logic [ADDR_W-1:0] wr_addr;
   logic              wr_in_range;
   logic [ADDR_W-1:0] rd_addr;
   logic              visible;

   // first pipeline stage: sampled on the pix_en clk that presents x/y
   logic [5:0]        rd_q;
   logic              vis_q;
   logic              hs_q, vs_q;
`ifdef VGA_FB_BORDER_EN
   logic              edge_px;
   logic              edge_q;
`endif

   assign wr_addr     = ADDR_W'(32'(wr.wr_y) * FB_W + 32'(wr.wr_x));
   assign wr_in_range = (32'(wr.wr_x) < FB_W) && (32'(wr.wr_y) < FB_H);
   assign visible     = (x < 10'd640) && (y < 10'd480);
   assign rd_addr     = ADDR_W'(32'(y >> SCALE_LOG2) * FB_W + 32'(x >> SCALE_LOG2));
`ifdef VGA_FB_BORDER_EN
   assign edge_px     = (x == 10'd0) || (x == 10'd639) || (y == 10'd0) || (y == 10'd479);
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (clear)       state_nx = CLEAR;
         CLEAR: if (cnt == LAST) state_nx = IDLE;
      endcase
   end

   // Writes accepted in the same cycle as clear still land; the sweep that
   // starts next clk zeroes them again.
   always_comb begin
      busy        = 1'b0;
      wr.wr_ready = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = wr_addr;
      mem_wdata   = wr.wr_data;
      case (state)
         IDLE: begin
            wr.wr_ready = 1'b1;
            mem_we      = wr.wr_valid && wr_in_range;
         end
         CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                 cnt <= '0;
      else if (state == CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   // ---------------- storage ----------------
   // No reset on the array or its read register so it maps onto block RAM;
   // the read register returns pre-write data on an address collision.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (pix_en && visible) rd_q <= mem[rd_addr];
   end

   // ---------------- display pipeline ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         vis_q  <= 1'b0;
         hs_q   <= 1'b0;
         vs_q   <= 1'b0;
`ifdef VGA_FB_BORDER_EN
         edge_q <= 1'b0;
`endif
      end else if (pix_en) begin
         vis_q  <= visible;
         hs_q   <= hsync_in;
         vs_q   <= vsync_in;
`ifdef VGA_FB_BORDER_EN
         edge_q <= visible && edge_px;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         {r, g, b} <= 6'd0;
      end else if (pix_en) begin
         hsync <= hs_q;
         vsync <= vs_q;
`ifdef VGA_FB_BORDER_EN
         if (edge_q)     {r, g, b} <= 6'b111111;
         else if (vis_q) {r, g, b} <= rd_q;
         else            {r, g, b} <= 6'd0;
`else
         if (vis_q)      {r, g, b} <= rd_q;
         else            {r, g, b} <= 6'd0;
`endif
      end
   end

endmodule

// File: tb/tb_vga_fb.sv
// tb/tb_vga_fb.sv - randomized scoreboard bench for vga_fb

module tb_vga_fb;

   localparam int W     = 160;
   localparam int H     = 120;
   localparam int DEPTH = W * H;

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_en;
   logic [9:0] x, y;
   logic       hsync_in, vsync_in;
   logic       clear;
   logic       busy, hsync, vsync;
   logic [1:0] r, g, b;

   vga_fb_if wif();

   vga_fb dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .wr(wif),
      .clear(clear), .busy(busy), .hsync(hsync), .vsync(vsync),
      .r(r), .g(g), .b(b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit       dc;
      bit       hs;
      bit       vs;
      bit [5:0] c;
   } item_t;

   item_t    q[$];
   int       errors = 0;
   int       checks = 0;
   bit       started = 0;

   // reference model state
   bit [5:0] m_mem   [DEPTH];
   bit       m_known [DEPTH];
   bit       m_busy = 0;
   int       m_pos  = 0;

   // stimulus registers read by tick()
   int       phase = 0;
   bit       rst_i = 1, wv = 0, clr = 0, hs_i = 0, vs_i = 0;
   int       wx_i = 0, wy_i = 0, wd_i = 0, px = 700, py = 500;
   bit       last_acc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected colour of a display pixel from the current model memory
   function automatic item_t expect_pix(int ex, int ey, bit h, bit v);
      item_t it;
      int    a;
      it.dc = 0; it.hs = h; it.vs = v; it.c = 6'd0;
      if (ex < 640 && ey < 480) begin
         a = (ey / 4) * W + (ex / 4);
         it.c  = m_mem[a];
         it.dc = !m_known[a];
`ifdef VGA_FB_BORDER_EN
         if (ex == 0 || ex == 639 || ey == 0 || ey == 479) begin
            it.c  = 6'b111111;
            it.dc = 0;
         end
`endif
      end
      return it;
   endfunction

   // one clk: drive inputs on the falling edge, update the model at the rising edge
   task automatic tick();
      bit pe;
      pe = (phase == 0);
      @(negedge clk);
      rst = rst_i; pix_en = pe; x = 10'(px); y = 10'(py);
      hsync_in = hs_i; vsync_in = vs_i; clear = clr;
      wif.wr_valid = wv; wif.wr_x = 8'(wx_i); wif.wr_y = 7'(wy_i); wif.wr_data = 6'(wd_i);
      if (started) begin
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("wr_ready", {31'd0, wif.wr_ready}, {31'd0, !m_busy});
      end
      @(posedge clk);
      last_acc = 0;
      if (rst_i) begin
         m_busy  = 0;
         started = 1;
         q.delete();
         q.push_back('0);
      end else begin
         if (pe && started) q.push_back(expect_pix(px, py, hs_i, vs_i));
         if (m_busy) begin
            m_mem[m_pos] = 6'd0;
            m_known[m_pos] = 1;
            m_pos++;
            if (m_pos == DEPTH) m_busy = 0;
         end else begin
            last_acc = wv;
            if (wv && wx_i < W && wy_i < H) begin
               m_mem[wy_i * W + wx_i]   = 6'(wd_i);
               m_known[wy_i * W + wx_i] = 1;
            end
            if (clr) begin
               m_busy = 1;
               m_pos  = 0;
            end
         end
      end
      phase = (phase + 1) % 4;
   endtask

   task automatic rand_pix();
      px = $urandom_range(0, 799);
      py = $urandom_range(0, 523);
      hs_i = 1'($urandom);
      vs_i = 1'($urandom);
   endtask

   // present one display pixel on the next pix_en clk
   task automatic pix(input int ex, input int ey);
      bit done;
      px = ex; py = ey; hs_i = 1'($urandom); vs_i = 1'($urandom);
      done = 0;
      for (int i = 0; i < 4 && !done; i++) begin
         done = (phase == 0);
         tick();
      end
   endtask

   task automatic write1(input int fx, input int fy, input int d);
      int  n;
      bit  idle_at_start;
      idle_at_start = !m_busy;
      wv = 1; wx_i = fx; wy_i = fy; wd_i = d;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 30000);
      wv = 0;
      if (!last_acc) chk("write_timeout", 32'(n), 32'd0);
      else if (idle_at_start) chk("write_one_clk", 32'(n), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_busy && n < 30000) begin
         if (phase == 0) rand_pix();
         tick();
         n++;
      end
      if (m_busy) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   // monitor: outputs after a pix_en edge belong to the previous pix_en's pixel
   always @(posedge clk) begin
      item_t it;
      if (started && pix_en && !rst) begin
         if (q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
         end else begin
            it = q.pop_front();
            #1;
            chk("syncs", {30'd0, hsync, vsync}, {30'd0, it.hs, it.vs});
            if (!it.dc) chk("colour", {26'd0, r, g, b}, {26'd0, it.c});
         end
      end
   end

   initial begin
      int n;
      // reset and check the idle outputs
      rst_i = 1;
      repeat (3) tick();
      #1 chk("rst_out", {27'd0, hsync, vsync, r, g, b}, 32'd0);
      rst_i = 0;

      // full clear with display reads, a re-pulsed clear, and a held write at the end
      clr = 1; tick(); clr = 0;
      n = 0;
      while (m_busy && n < 25000) begin
         if (phase == 0) rand_pix();
         clr = (n == 500);
         if (m_pos > DEPTH - 20) begin
            wv = 1; wx_i = 3; wy_i = 2; wd_i = 21;
         end
         tick();
         n++;
      end
      clr = 0;
      tick();
      chk("held_write_first_idle", {31'd0, last_acc}, 32'd1);
      wv = 0;

      // top-left pixel and its neighbour
      write1(0, 0, 6'b110000);
      write1(1, 0, 6'($urandom));
      for (int yy = 0; yy < 4; yy++)
         for (int xx = 0; xx < 5; xx++) pix(xx, yy);

      // bottom-right pixel and the blank region
      write1(159, 119, 6'b000011);
      for (int yy = 476; yy < 480; yy++)
         for (int xx = 636; xx < 640; xx++) pix(xx, yy);
      for (int i = 0; i < 6; i++) pix($urandom_range(640, 799), $urandom_range(0, 523));

      // out-of-range writes are accepted and dropped
      write1(200, 5, 6'b111111);
      write1(5, 120, 6'b111111);
      pix(160, 24); pix(20, 479); pix(800 - 161, 0);

      // randomized writes, reads and same-address collisions
      for (int i = 0; i < 3000; i++) begin
         wv   = ($urandom_range(0, 3) == 0);
         wx_i = ($urandom_range(0, 7) == 0) ? $urandom_range(160, 255) : $urandom_range(0, 159);
         wy_i = ($urandom_range(0, 7) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 119);
         wd_i = $urandom_range(0, 63);
         if (phase == 0) begin
            rand_pix();
            if ($urandom_range(0, 1) == 1 && wx_i < W && wy_i < H) begin
               px = wx_i * 4 + $urandom_range(0, 3);
               py = wy_i * 4 + $urandom_range(0, 3);
            end
         end
         tick();
      end
      wv = 0;

      // reset in the middle of a clear
      clr = 1; tick(); clr = 0;
      n = 0;
      while (m_pos < 100 && n < 200) begin
         if (phase == 0) rand_pix();
         tick();
         n++;
      end
      rst_i = 1; tick(); rst_i = 0;
      #1 chk("abort_out", {27'd0, hsync, vsync, r, g, b}, 32'd0);
      for (int i = 0; i < 40; i++) pix($urandom_range(0, 400), $urandom_range(0, 7));
      for (int i = 0; i < 20; i++) pix($urandom_range(0, 799), $urandom_range(0, 523));

      // write and clear in the same cycle
      wv = 1; wx_i = 10; wy_i = 10; wd_i = 63; clr = 1;
      tick();
      chk("wr_with_clear", {31'd0, last_acc}, 32'd1);
      wv = 0; clr = 0;
      wait_idle();
      pix(40, 40); pix(43, 43); pix(0, 0); pix(2, 0);

      // display edges on an all-zero framebuffer
      for (int i = 0; i < 4; i++) begin
         pix(0, $urandom_range(0, 479));
         pix(639, $urandom_range(0, 479));
         pix($urandom_range(0, 639), 0);
         pix($urandom_range(0, 639), 479);
         pix($urandom_range(1, 638), $urandom_range(1, 478));
      end
      pix(700, 500);
      pix(700, 500);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
